// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_stage                                                      |
// | Brief   : Instruction fetch with ready-handshake imem port, one-entry skid |
// |           buffer for decode stalls, branch redirect and HLT freeze.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [15:0] imem_data_i,
  output logic [15:0] pc_o,
  output logic [15:0] instr_fd_o,
  output logic [15:0] pc_plus2_fd_o,
  output logic        valid_fd_o,
  output logic        hlt_f_o
);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instrFd;
  logic [15:0] r_pcPlus2Fd;
  logic        r_validFd;
  logic [15:0] r_skidInstr;
  logic [15:0] r_skidPcPlus2;

  logic        w_req;
  logic        w_done;
  logic        w_fetchHlt;
  logic        w_skidHlt;
  logic [15:0] w_pcPlus2;

  assign w_pcPlus2  = r_pc + 16'd2;
  assign w_req      = rst_n & (r_state == ST_FETCH) & ~redirect_i;
  assign w_done     = w_req & imem_ready_i;
  assign w_fetchHlt = (imem_data_i[15:12] == HALT_OPCODE);
  assign w_skidHlt  = (r_skidInstr[15:12] == HALT_OPCODE);

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc;
  assign pc_o          = r_pc;
  assign instr_fd_o    = r_instrFd;
  assign pc_plus2_fd_o = r_pcPlus2Fd;
  assign valid_fd_o    = r_validFd;
  assign hlt_f_o       = (r_state == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_instrFd     <= NOP_INSTR;
      r_pcPlus2Fd   <= 16'h0000;
      r_validFd     <= 1'b0;
      r_skidInstr   <= NOP_INSTR;
      r_skidPcPlus2 <= 16'h0000;
    end else if (redirect_i) begin
      // Redirect wins over everything, including a word returned this cycle.
      r_state       <= ST_FETCH;
      r_pc          <= redirect_pc_i;
      r_instrFd     <= NOP_INSTR;
      r_pcPlus2Fd   <= 16'h0000;
      r_validFd     <= 1'b0;
      r_skidInstr   <= NOP_INSTR;
      r_skidPcPlus2 <= 16'h0000;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_done) begin
            if (!stall_i) begin
              r_instrFd   <= imem_data_i;
              r_pcPlus2Fd <= w_pcPlus2;
              r_validFd   <= 1'b1;
              if (w_fetchHlt) begin
                r_state <= ST_HALTED;
              end else begin
                r_pc <= w_pcPlus2;
              end
            end else begin
              r_skidInstr   <= imem_data_i;
              r_skidPcPlus2 <= w_pcPlus2;
              r_state       <= ST_HOLD;
              if (!w_fetchHlt) begin
                r_pc <= w_pcPlus2;
              end
            end
          end else if (!stall_i) begin
            r_instrFd   <= NOP_INSTR;
            r_pcPlus2Fd <= 16'h0000;
            r_validFd   <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            r_instrFd   <= r_skidInstr;
            r_pcPlus2Fd <= r_skidPcPlus2;
            r_validFd   <= 1'b1;
            r_state     <= w_skidHlt ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: begin
          // The HLT itself drains to decode, then only bubbles follow.
          if (!stall_i) begin
            r_instrFd   <= NOP_INSTR;
            r_pcPlus2Fd <= 16'h0000;
            r_validFd   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fetch_stage                                                   |
// | Brief   : Self-checking bench for fetch_stage: directed scenarios plus     |
// |           random stall/ready/redirect traffic against a program-order model|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = 16'h0000;
  logic        imem_ready_i = 1'b0;
  logic [15:0] imem_data_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [15:0] pc_o;
  logic [15:0] instr_fd_o;
  logic [15:0] pc_plus2_fd_o;
  logic        valid_fd_o;
  logic        hlt_f_o;

  logic [15:0] junk = 16'hDEAD;
  logic [15:0] mem [0:32767];

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // Expected decode-visible stream: {instr, pc+2} in program order
  logic [31:0] expQ[$];
  logic        prevValid = 1'b0;
  logic [15:0] prevInstr = 16'h0000;
  logic [15:0] prevPc2 = 16'h0000;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_data_i  (imem_data_i),
    .pc_o         (pc_o),
    .instr_fd_o   (instr_fd_o),
    .pc_plus2_fd_o(pc_plus2_fd_o),
    .valid_fd_o   (valid_fd_o),
    .hlt_f_o      (hlt_f_o)
  );

  always #5 clk = ~clk;

  assign imem_data_i = imem_ready_i ? mem[imem_addr_o[15:1]] : junk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program stream from a start address: sequential words until an HLT
  task automatic refill(input logic [15:0] startPc);
    logic [15:0] pc;
    logic [15:0] w;
    logic [15:0] nxt;
    expQ.delete();
    pc = startPc;
    for (int n = 0; n < 512; n++) begin
      w   = mem[pc[15:1]];
      nxt = pc + 16'd2;
      expQ.push_back({w, nxt});
      if (w[15:12] == 4'hF) break;
      pc = nxt;
    end
  endtask

  // Monitor: inputs seen at a negedge are those applied at the edge just passed
  always @(negedge clk) begin
    if (!rst_n) begin
      refill(16'h0000);
      prevValid = 1'b0;
    end else begin
      chk("addr_eq_pc", {16'h0, imem_addr_o}, {16'h0, pc_o});
      if (hlt_f_o) chk("req_in_halt", {31'h0, imem_req_o}, 32'h0);
      if (valid_fd_o) chk("hlt_flag", {31'h0, hlt_f_o}, {31'h0, instr_fd_o[15:12] == 4'hF});
      if (prevValid && !stall_i) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_delivery: got %h expected none at %0t", prevInstr, $time);
        end else begin
          logic [31:0] e;
          e = expQ.pop_front();
          chk("deliv_instr", {16'h0, prevInstr}, {16'h0, e[31:16]});
          chk("deliv_pc2", {16'h0, prevPc2}, {16'h0, e[15:0]});
          delivered++;
        end
      end
      if (redirect_i) refill(redirect_pc_i);
      prevValid = valid_fd_o;
      prevInstr = instr_fd_o;
      prevPc2   = pc_plus2_fd_o;
    end
  end

  task automatic expFd(input string name, input logic [15:0] ins, input logic [15:0] p2, input logic v);
    chk({name, "_instr"}, {16'h0, instr_fd_o}, {16'h0, ins});
    chk({name, "_pc2"}, {16'h0, pc_plus2_fd_o}, {16'h0, p2});
    chk({name, "_valid"}, {31'h0, valid_fd_o}, {31'h0, v});
  endtask

  task automatic pulseReset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0100;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    mem[3] = 16'h4444; mem[4] = 16'hF000;
    mem[16'h0010] = 16'h6666; mem[16'h0020] = 16'h5555;
    mem[16'h7FFF] = 16'h7777;
    imem_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_pc", {16'h0, pc_o}, 32'h0);
    expFd("rst", 16'h0000, 16'h0000, 1'b0);
    chk("rst_hlt", {31'h0, hlt_f_o}, 32'h0);
    chk("rst_req", {31'h0, imem_req_o}, 32'h0);

    // Zero-wait streaming
    #1 rst_n = 1'b1;
    @(negedge clk); expFd("s1", 16'h1111, 16'h0002, 1'b1);
    @(negedge clk); expFd("s2", 16'h2222, 16'h0004, 1'b1);
    @(negedge clk); expFd("s3", 16'h3333, 16'h0006, 1'b1);

    // Two wait cycles at address 4
    pulseReset();
    @(negedge clk); expFd("w1", 16'h1111, 16'h0002, 1'b1);
    @(negedge clk); chk("w_addr0", {16'h0, imem_addr_o}, 32'h4);
    #1 imem_ready_i = 1'b0;
    @(negedge clk); expFd("w_bub1", 16'h0000, 16'h0000, 1'b0);
    chk("w_addr1", {16'h0, imem_addr_o}, 32'h4);
    chk("w_req1", {31'h0, imem_req_o}, 32'h1);
    @(negedge clk); expFd("w_bub2", 16'h0000, 16'h0000, 1'b0);
    chk("w_addr2", {16'h0, imem_addr_o}, 32'h4);
    #1 imem_ready_i = 1'b1;
    @(negedge clk); expFd("w_data", 16'h3333, 16'h0006, 1'b1);

    // Three-cycle stall while address 2 completes
    pulseReset();
    @(negedge clk); expFd("st0", 16'h1111, 16'h0002, 1'b1);
    #1 stall_i = 1'b1;
    @(negedge clk); expFd("st1", 16'h1111, 16'h0002, 1'b1);
    chk("st1_req", {31'h0, imem_req_o}, 32'h0);
    chk("st1_pc", {16'h0, pc_o}, 32'h4);
    @(negedge clk); chk("st2_req", {31'h0, imem_req_o}, 32'h0);
    @(negedge clk); expFd("st3", 16'h1111, 16'h0002, 1'b1);
    chk("st3_req", {31'h0, imem_req_o}, 32'h0);
    #1 stall_i = 1'b0;
    @(negedge clk); expFd("st_skid", 16'h2222, 16'h0004, 1'b1);
    chk("st_req", {31'h0, imem_req_o}, 32'h1);
    @(negedge clk); expFd("st_next", 16'h3333, 16'h0006, 1'b1);

    // Redirect together with stall
    #1 begin stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'h0040; end
    @(negedge clk); expFd("rd", 16'h0000, 16'h0000, 1'b0);
    chk("rd_pc", {16'h0, pc_o}, 32'h40);
    #1 begin stall_i = 1'b0; redirect_i = 1'b0; end
    @(negedge clk); expFd("rd_fetch", 16'h5555, 16'h0042, 1'b1);

    // HLT at 0x0008
    pulseReset();
    repeat (4) @(negedge clk);
    chk("h_pre_pc", {16'h0, pc_o}, 32'h8);
    chk("h_pre_hlt", {31'h0, hlt_f_o}, 32'h0);
    @(negedge clk); expFd("h_cap", 16'hF000, 16'h000A, 1'b1);
    chk("h_flag", {31'h0, hlt_f_o}, 32'h1);
    chk("h_pc", {16'h0, pc_o}, 32'h8);
    repeat (3) @(negedge clk);
    chk("h_pc_hold", {16'h0, pc_o}, 32'h8);
    chk("h_req", {31'h0, imem_req_o}, 32'h0);
    chk("h_flag_hold", {31'h0, hlt_f_o}, 32'h1);
    #1 begin redirect_i = 1'b1; redirect_pc_i = 16'h0020; end
    @(negedge clk); chk("h_exit", {31'h0, hlt_f_o}, 32'h0);
    chk("h_exit_pc", {16'h0, pc_o}, 32'h20);
    #1 redirect_i = 1'b0;
    @(negedge clk); expFd("h_resume", 16'h6666, 16'h0022, 1'b1);

    // PC wrap at 0xFFFE
    #1 begin redirect_i = 1'b1; redirect_pc_i = 16'hFFFE; end
    @(negedge clk); chk("wr_pc", {16'h0, pc_o}, 32'hFFFE);
    #1 redirect_i = 1'b0;
    @(negedge clk); expFd("wr", 16'h7777, 16'h0000, 1'b1);
    chk("wr_next_pc", {16'h0, pc_o}, 32'h0);
    @(negedge clk); expFd("wr_after", 16'h1111, 16'h0002, 1'b1);

    // Random traffic
    #1 rst_n = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (($urandom % 48) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h1;
      mem[i] = w;
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      stall_i       = (($urandom % 4) == 0);
      imem_ready_i  = (($urandom % 3) != 0);
      junk          = 16'($urandom);
      redirect_i    = (($urandom % 40) == 0);
      redirect_pc_i = (($urandom % 8) == 0) ? 16'hFFFC : {15'($urandom), 1'b0};
      rst_n         = (($urandom % 500) != 0);
    end
    @(negedge clk);
    #1 begin stall_i = 1'b0; redirect_i = 1'b0; imem_ready_i = 1'b1; rst_n = 1'b1; end
    repeat (10) @(negedge clk);
    chk("progress", {31'h0, delivered > 300}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
